// File: rtl/grid_mm_reader.sv
// grid_mm_reader: Avalon-MM reader of the playfield with a coherent snapshot bank,
// row-clear counter and game-over latch. Define GRID_IRQ_EN to enable the irq output.
module grid_mm_reader #(
    parameter int ROWS   = 20,
    parameter int COLS   = 10,
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [ROWS*COLS-1:0] grid_state,
    input  logic                 row_cleared,
    input  logic                 game_over,
    input  logic [ADDR_W-1:0]    avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    output logic [31:0]          avs_readdata,
    output logic                 avs_readdatavalid,
    output logic                 avs_waitrequest,
    output logic                 irq
);
    localparam logic [ADDR_W-1:0] STATUS_ADDR  = ADDR_W'(ROWS);
    localparam logic [ADDR_W-1:0] CONTROL_ADDR = ADDR_W'(ROWS + 1);

    typedef enum logic {IDLE, CAPTURE} state_t;

    state_t                 state_q, state_d;
    logic [ROWS*COLS-1:0]   snap_q, snap_d;
    logic                   snap_valid_q, snap_valid_d;
    logic                   clr_sticky_q, clr_sticky_d;
    logic                   go_sticky_q, go_sticky_d;
    logic [7:0]             clr_count_q, clr_count_d;
    logic                   auto_en_q, auto_en_d;
    logic                   irq_mask_q, irq_mask_d;
    logic                   rc_q, rc_d;
    logic                   go_q, go_d;
    logic [31:0]            readdata_q, readdata_d;
    logic                   rdv_q, rdv_d;
    logic                   waitreq_q, waitreq_d;
    logic                   irq_q, irq_d;

    logic rd_acc, ctrl_wr, dirty, clr_ev, go_ev;
    logic unused_wdata;

    assign unused_wdata = ^avs_writedata[31:3];

    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        snap_valid_d = snap_valid_q;
        clr_sticky_d = clr_sticky_q;
        go_sticky_d  = go_sticky_q;
        clr_count_d  = clr_count_q;
        auto_en_d    = auto_en_q;
        irq_mask_d   = irq_mask_q;
        rc_d         = row_cleared;
        go_d         = game_over;
        readdata_d   = '0;

        rd_acc  = avs_read && (state_q == IDLE);
        ctrl_wr = avs_write && (state_q == IDLE) && (avs_address == CONTROL_ADDR);
        dirty   = (grid_state != snap_q);
        clr_ev  = row_cleared && !rc_q;
        go_ev   = game_over && !go_q;

        if (ctrl_wr) begin
            auto_en_d = avs_writedata[2];
`ifdef GRID_IRQ_EN
            irq_mask_d = avs_writedata[3];
`endif
            if (avs_writedata[1]) begin
                clr_sticky_d = 1'b0;
                go_sticky_d  = 1'b0;
                clr_count_d  = '0;
            end
        end
        // Events are applied after the clear so a coincident event survives it.
        if (clr_ev) begin
            clr_sticky_d = 1'b1;
            if (clr_count_d != 8'hFF)
                clr_count_d = clr_count_d + 8'd1;
        end
        if (go_ev)
            go_sticky_d = 1'b1;

        case (state_q)
            IDLE: begin
                if ((ctrl_wr && avs_writedata[0]) || (auto_en_q && dirty))
                    state_d = CAPTURE;
            end
            CAPTURE: begin
                snap_d       = grid_state;
                snap_valid_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        rdv_d = rd_acc;
        if (rd_acc) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                if (avs_address == ADDR_W'(r))
                    readdata_d[COLS-1:0] = snap_q[r*COLS +: COLS];
            end
            if (avs_address == STATUS_ADDR)
                readdata_d = {16'b0, clr_count_q, 3'b0, dirty, go_sticky_q,
                              game_over, clr_sticky_q, snap_valid_q};
            if (avs_address == CONTROL_ADDR)
                readdata_d = {28'b0, irq_mask_q, auto_en_q, 2'b0};
        end

        waitreq_d = (state_d == CAPTURE);
`ifdef GRID_IRQ_EN
        irq_d = irq_mask_q && (clr_sticky_q || go_sticky_q);
`else
        irq_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            snap_q       <= '0;
            snap_valid_q <= 1'b0;
            clr_sticky_q <= 1'b0;
            go_sticky_q  <= 1'b0;
            clr_count_q  <= '0;
            auto_en_q    <= 1'b0;
            irq_mask_q   <= 1'b0;
            rc_q         <= 1'b0;
            go_q         <= 1'b0;
            readdata_q   <= '0;
            rdv_q        <= 1'b0;
            waitreq_q    <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            snap_valid_q <= snap_valid_d;
            clr_sticky_q <= clr_sticky_d;
            go_sticky_q  <= go_sticky_d;
            clr_count_q  <= clr_count_d;
            auto_en_q    <= auto_en_d;
            irq_mask_q   <= irq_mask_d;
            rc_q         <= rc_d;
            go_q         <= go_d;
            readdata_q   <= readdata_d;
            rdv_q        <= rdv_d;
            waitreq_q    <= waitreq_d;
            irq_q        <= irq_d;
        end
    end

    assign avs_readdata      = readdata_q;
    assign avs_readdatavalid = rdv_q;
    assign avs_waitrequest   = waitreq_q;
    assign irq               = irq_q;
endmodule

// File: tb/tb_grid_mm_reader.sv
// Scoreboard bench for grid_mm_reader: reads push model expectations, a monitor
// pops them on readdatavalid. Irq expectations follow GRID_IRQ_EN.
module tb_grid_mm_reader;
    localparam int ROWS = 20;
    localparam int COLS = 10;
    localparam int AW   = 5;
    localparam int GW   = ROWS * COLS;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [GW-1:0] grid_state = '0;
    logic          row_cleared = 1'b0;
    logic          game_over = 1'b0;
    logic [AW-1:0] avs_address = '0;
    logic          avs_read = 1'b0;
    logic          avs_write = 1'b0;
    logic [31:0]   avs_writedata = '0;
    logic [31:0]   avs_readdata;
    logic          avs_readdatavalid;
    logic          avs_waitrequest;
    logic          irq;

    grid_mm_reader #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .grid_state(grid_state),
        .row_cleared(row_cleared), .game_over(game_over),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .avs_readdatavalid(avs_readdatavalid), .avs_waitrequest(avs_waitrequest),
        .irq(irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model of the register-visible state
    logic [GW-1:0] m_snap;
    bit m_valid, m_clr, m_go, m_auto, m_mask;
    int m_cnt;

    logic [31:0] q_data[$];
    int          q_cyc[$];
    int          q_addr[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_snap = '0; m_valid = 0; m_clr = 0; m_go = 0; m_auto = 0; m_mask = 0; m_cnt = 0;
    endtask

    function automatic logic [31:0] exp_read(input int a);
        logic [31:0] v = '0;
        if (a < ROWS) begin
            v[COLS-1:0] = m_snap[a*COLS +: COLS];
        end else if (a == ROWS) begin
            v[0] = m_valid; v[1] = m_clr; v[2] = game_over; v[3] = m_go;
            v[4] = (grid_state != m_snap);
            v[15:8] = 8'(m_cnt);
        end else if (a == ROWS + 1) begin
            v[2] = m_auto; v[3] = m_mask;
        end
        return v;
    endfunction

    function automatic logic exp_irq();
`ifdef GRID_IRQ_EN
        return m_mask && (m_clr || m_go);
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge clk) begin
        if (reset_n && avs_readdatavalid) begin
            if (q_data.size() == 0) begin
                chk("spurious_rdv", 32'd1, 32'd0);
            end else begin
                chk($sformatf("rd_addr%0d", q_addr.pop_front()), avs_readdata, q_data.pop_front());
                chk("rdv_latency", 32'(cyc), 32'(q_cyc.pop_front()));
            end
        end
    end

    task automatic issue_read(input int a, input bit sync, output int stalls);
        if (sync) @(negedge clk);
        avs_address = AW'(a);
        avs_read = 1'b1;
        stalls = 0;
        while (avs_waitrequest && stalls < 8) begin
            @(negedge clk);
            stalls++;
        end
        if (stalls >= 8) chk("read_wait_bound", 32'd1, 32'd0);
        else begin
            q_data.push_back(exp_read(a));
            q_cyc.push_back(cyc + 1);
            q_addr.push_back(a);
        end
    endtask

    task automatic do_read(input int a);
        int s;
        issue_read(a, 1'b1, s);
        @(negedge clk) avs_read = 1'b0;
    endtask

    task automatic do_write(input int a, input logic [31:0] d, input int settle);
        int s = 0;
        @(negedge clk);
        avs_address = AW'(a); avs_writedata = d; avs_write = 1'b1;
        while (avs_waitrequest && s < 8) begin
            @(negedge clk);
            s++;
        end
        if (s >= 8) chk("write_wait_bound", 32'd1, 32'd0);
        if (a == ROWS + 1) begin
            m_auto = d[2];
`ifdef GRID_IRQ_EN
            m_mask = d[3];
`endif
            if (d[1]) begin m_clr = 0; m_go = 0; m_cnt = 0; end
            if (d[0] || (m_auto && grid_state != m_snap)) begin
                m_snap = grid_state; m_valid = 1;
            end
        end
        @(negedge clk) avs_write = 1'b0;
        repeat (settle) @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk) row_cleared = 1'b1;
        m_clr = 1;
        if (m_cnt < 255) m_cnt++;
        @(negedge clk) row_cleared = 1'b0;
    endtask

    task automatic set_grid(input logic [GW-1:0] g);
        @(negedge clk) grid_state = g;
        if (m_auto) begin
            repeat (3) @(negedge clk);
            m_snap = g; m_valid = 1;
        end
    endtask

    task automatic set_go(input bit v);
        @(negedge clk);
        if (v && !game_over) m_go = 1;
        game_over = v;
    endtask

    function automatic logic [GW-1:0] rand_grid();
        logic [223:0] t;
        for (int i = 0; i < 7; i++) t[i*32 +: 32] = $urandom;
        return t[GW-1:0];
    endfunction

    initial begin
        int s;
        logic [GW-1:0] g;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_rdv", 32'(avs_readdatavalid), 32'd0);
        chk("reset_wait", 32'(avs_waitrequest), 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);
        chk("reset_rdata", avs_readdata, 32'd0);
        reset_n = 1'b1;

        do_read(ROWS);
        g = '0; g[194] = 1'b1;
        set_grid(g);
        do_write(ROWS + 1, 32'h1, 3);
        do_read(19);
        do_read(ROWS);

        g[0] = 1'b1;
        set_grid(g);
        do_read(0);
        do_read(ROWS);
        do_write(ROWS + 1, 32'h4, 3);
        do_read(0);
        do_write(ROWS + 1, 32'h0, 2);

        repeat (3) pulse_clear();
        do_read(ROWS);
        do_write(ROWS + 1, 32'h2, 2);
        repeat (300) pulse_clear();
        do_read(ROWS);
        // Clear write coincident with a new event: event wins
        @(negedge clk);
        avs_address = AW'(ROWS + 1); avs_writedata = 32'h2; avs_write = 1'b1; row_cleared = 1'b1;
        m_go = 0; m_clr = 1; m_cnt = 1;
        @(negedge clk);
        avs_write = 1'b0; row_cleared = 1'b0;
        do_read(ROWS);

        // Read presented in the cycle CAPTURE is entered stalls once and sees the new grid
        set_grid(rand_grid());
        do_write(ROWS + 1, 32'h1, 0);
        chk("wait_in_capture", 32'(avs_waitrequest), 32'd1);
        issue_read(7, 1'b0, s);
        chk("stall_cycles", 32'(s), 32'd1);
        @(negedge clk) avs_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue_read(i * 5, 1'b1, s);
        end
        @(negedge clk) avs_read = 1'b0;

        do_write(ROWS + 1, 32'h8, 3);
        set_go(1'b1);
        repeat (2) @(negedge clk);
        chk("irq_after_go", 32'(irq), 32'(exp_irq()));
        do_read(ROWS);
        do_read(ROWS + 1);
        do_write(ROWS + 1, 32'hA, 3);
        chk("irq_after_clear", 32'(irq), 32'(exp_irq()));
        do_read(25);
        do_write(3, 32'hFFFF_FFFF, 2);
        do_read(3);

        // Reset while CAPTURE is in flight must leave no partial snapshot
        set_go(1'b0);
        set_grid(rand_grid());
        do_write(ROWS + 1, 32'h1, 0);
        reset_n = 1'b0;
        model_reset();
        #1 chk("reset_mid_capture_wait", 32'(avs_waitrequest), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        do_read(4);
        do_read(ROWS);

        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 5))
                0: do_read($urandom_range(0, 31));
                1: begin
                    for (int k = 0; k < 4; k++) issue_read($urandom_range(0, 31), 1'b1, s);
                    @(negedge clk) avs_read = 1'b0;
                end
                2: repeat ($urandom_range(1, 3)) pulse_clear();
                3: set_grid(rand_grid());
                4: begin
                    if ($urandom_range(0, 3) == 0) do_write($urandom_range(0, 31), $urandom, 3);
                    else do_write(ROWS + 1, 32'($urandom_range(0, 15)), 3);
                end
                default: set_go(1'($urandom_range(0, 1)));
            endcase
            repeat (2) @(negedge clk);
            chk("irq_rand", 32'(irq), 32'(exp_irq()));
        end

        repeat (4) @(negedge clk);
        chk("pending_reads", 32'(q_data.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
